video_clken_gen: RTL and testbench

N-channel fractional clock-enable generator for the video subsystem: from a single reference clock it produces per-channel one-cycle enable strobes at programmable average rates, using one phase accumulator per channel. It replaces fixed PLL output clocks in downstream single-clock logic (pixel, sample and refresh enables) and supports runtime reprogramming of each rate through a valid/ready write port. A `locked` indication is reasserted only after a programmable settle time following reset or any reconfiguration.

---
 rtl/video_clken_pkg.sv | 22 ++
 rtl/video_clken_phase_acc.sv | 41 ++++
 rtl/video_clken_gen.sv | 102 ++++++++++
 tb/tb_video_clken_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/video_clken_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Default increments target a 50 MHz reference clock.
package video_clken_pkg;

   typedef enum logic [1:0] {
      LOCKING = 2'd0,
      APPLY   = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int DEFAULT_ACC_WIDTH = 32;

   // 50 MHz reference: 25 MHz, 33.333 MHz and 12.5 MHz average rates
   localparam logic [31:0] INC_25M0 = 32'h8000_0000;
   localparam logic [31:0] INC_33M3 = 32'hAAAA_AAAB;
   localparam logic [31:0] INC_12M5 = 32'h4000_0000;

   function automatic int SEL_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/video_clken_phase_acc.sv
// One phase accumulator channel: increment register, accumulator and a
// registered carry that serves as the channel's enable strobe.
module video_clken_phase_acc #(
   parameter int                   ACC_WIDTH = 32,
   parameter logic [ACC_WIDTH-1:0] INC_RESET = '0
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 load,
   input  logic [ACC_WIDTH-1:0] load_inc,
   output logic                 o_carry
);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_inc;
   logic                 r_carry;
   logic [ACC_WIDTH:0]   w_sum;

   assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
   assign o_carry = r_carry;

   // A load restarts the phase from zero; a stopped channel keeps its phase.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_acc   <= '0;
         r_inc   <= INC_RESET;
         r_carry <= 1'b0;
      end else if (load) begin
         r_acc   <= '0;
         r_inc   <= load_inc;
         r_carry <= 1'b0;
      end else if (run) begin
         r_acc   <= w_sum[ACC_WIDTH-1:0];
         r_carry <= w_sum[ACC_WIDTH];
      end else begin
         r_carry <= 1'b0;
      end
   end

endmodule

// File: rtl/video_clken_gen.sv
// N-channel fractional clock-enable generator with runtime rate writes
// and a settle-time based lock indication.
module video_clken_gen
   import video_clken_pkg::*;
#(
   parameter int NUM_CLOCKS  = 3,
   parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
   parameter int LOCK_CYCLES = 1024,
   parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INC_DEFAULT =
      {INC_12M5, INC_33M3, INC_25M0}
) (
   input  logic                           refclk,
   input  logic                           rst,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [SEL_W(NUM_CLOCKS)-1:0]   cfg_sel,
   input  logic [ACC_WIDTH-1:0]           cfg_inc,
   input  logic [NUM_CLOCKS-1:0]          ch_enable,
   output logic [NUM_CLOCKS-1:0]          outclk_en,
   output logic                           locked
);

   localparam int              SW      = SEL_W(NUM_CLOCKS);
   localparam int              CNT_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [SW:0]     NUM_SEL = (SW+1)'(NUM_CLOCKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   state_t                r_state;
   state_t                w_nextState;
   logic [CNT_W-1:0]      r_lockCnt;
   logic                  r_locked;
   logic [SW-1:0]         r_applySel;
   logic                  w_write;
   logic [NUM_CLOCKS-1:0] w_held;
   logic [NUM_CLOCKS-1:0] w_load;

   // Out-of-range selects still complete the handshake but change nothing.
   assign w_write = cfg_valid & cfg_ready & ({1'b0, cfg_sel} < NUM_SEL);
   assign locked  = r_locked;

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state    <= LOCKING;
         r_lockCnt  <= '0;
         r_locked   <= 1'b0;
         r_applySel <= '0;
      end else begin
         r_state  <= w_nextState;
         r_locked <= (w_nextState == LOCKED);
         if (r_state == LOCKING && w_nextState == LOCKING)
            r_lockCnt <= r_lockCnt + 1'b1;
         else
            r_lockCnt <= '0;
         if (w_write)
            r_applySel <= cfg_sel;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         LOCKING: begin
            if (w_write)
               w_nextState = APPLY;
            else if (r_lockCnt == CNT_LAST)
               w_nextState = LOCKED;
         end
         APPLY:   w_nextState = LOCKING;
         LOCKED: begin
            if (w_write)
               w_nextState = APPLY;
         end
         default: w_nextState = LOCKING;
      endcase
   end

   // The reprogrammed channel sits idle for the single APPLY cycle.
   always_comb begin
      cfg_ready = (r_state != APPLY) & ~rst;
      w_held    = '0;
      w_load    = '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         w_held[i] = (r_state == APPLY) && (r_applySel == SW'(i));
         w_load[i] = w_write && (cfg_sel == SW'(i));
      end
   end

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
      video_clken_phase_acc #(
         .ACC_WIDTH (ACC_WIDTH),
         .INC_RESET (INC_DEFAULT[g*ACC_WIDTH +: ACC_WIDTH])
      ) u_acc (
         .refclk   (refclk),
         .rst      (rst),
         .run      (ch_enable[g] & ~w_held[g]),
         .load     (w_load[g]),
         .load_inc (cfg_inc),
         .o_carry  (outclk_en[g])
      );
   end

endmodule

// File: tb/tb_video_clken_gen.sv
// Randomized bench for video_clken_gen: every cycle is compared against a
// cycle-numbered model that tracks unwrapped phase and settle deadlines.
module tb_video_clken_gen;

   localparam int N = 3;
   localparam int W = 32;
   localparam int L = 16;

   logic          refclk;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_sel;
   logic [W-1:0]  cfg_inc;
   logic [N-1:0]  ch_enable;
   logic [N-1:0]  outclk_en;
   logic          locked;

   video_clken_gen #(
      .NUM_CLOCKS  (N),
      .ACC_WIDTH   (W),
      .LOCK_CYCLES (L),
      .INC_DEFAULT ({32'h4000_0000, 32'hAAAA_AAAB, 32'h8000_0000})
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_sel   (cfg_sel),
      .cfg_inc   (cfg_inc),
      .ch_enable (ch_enable),
      .outclk_en (outclk_en),
      .locked    (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Reference model state: phase is kept unwrapped, so a strobe is simply
   // a change in the integer number of whole turns.
   logic [W-1:0]   defInc [N] = '{32'h8000_0000, 32'hAAAA_AAAB, 32'h4000_0000};
   longint unsigned mPhase [N];
   logic [W-1:0]   mInc [N];
   logic [N-1:0]   mOut;
   bit             mApply;
   int             mApplySel;
   longint         mLockStart;
   bit             mLocked;
   longint         cyc;
   int             errors;
   int             checks;
   int             strobeCnt [N];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic modelStep();
      bit              wr;
      bit              held;
      longint unsigned nxt;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            mPhase[i] = 0;
            mInc[i]   = defInc[i];
         end
         mOut       = '0;
         mApply     = 0;
         mLockStart = cyc + 1;
         mLocked    = 0;
      end else begin
         wr = cfg_valid && !mApply && (cfg_sel < N);
         for (int i = 0; i < N; i++) begin
            held = mApply && (mApplySel == i);
            if (wr && cfg_sel == i) begin
               mInc[i]   = cfg_inc;
               mPhase[i] = 0;
               mOut[i]   = 1'b0;
            end else if (ch_enable[i] && !held) begin
               nxt       = mPhase[i] + mInc[i];
               mOut[i]   = ((nxt >> W) != (mPhase[i] >> W));
               mPhase[i] = nxt;
            end else begin
               mOut[i] = 1'b0;
            end
         end
         if (wr) begin
            mApply     = 1;
            mApplySel  = cfg_sel;
            mLockStart = cyc + 2;
         end else begin
            mApply = 0;
         end
         mLocked = !mApply && (cyc + 1 >= mLockStart + L);
      end
      cyc++;
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, then steps the model.
   task automatic applyStimulus(input bit r, input bit v, input logic [1:0] sel,
                                input logic [W-1:0] inc, input logic [N-1:0] en);
      rst       = r;
      cfg_valid = v;
      cfg_sel   = sel;
      cfg_inc   = inc;
      ch_enable = en;
      @(negedge refclk);
      checkOutput("outclk_en", 64'(outclk_en), 64'(mOut));
      checkOutput("locked", 64'(locked), 64'(mLocked));
      checkOutput("cfg_ready", 64'(cfg_ready), 64'(!r && !mApply));
      for (int i = 0; i < N; i++) strobeCnt[i] += int'(outclk_en[i]);
      @(posedge refclk);
      modelStep();
      #1;
   endtask

   task automatic clearCounts();
      for (int i = 0; i < N; i++) strobeCnt[i] = 0;
   endtask

   initial begin
      logic [N-1:0] en;
      errors = 0;
      checks = 0;
      cyc    = 0;
      mOut   = '0;
      mApply = 0;
      mApplySel  = 0;
      mLockStart = 0;
      mLocked    = 0;
      clearCounts();
      rst = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_inc = '0; ch_enable = '1;
      @(posedge refclk);
      modelStep();
      #1;

      for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 3'b111);

      // Defaults after reset release: ch1 runs at exactly two thirds.
      clearCounts();
      for (int k = 0; k < 3000; k++) applyStimulus(0, 0, 0, 0, 3'b111);
      checkOutput("ch1Rate2of3", 64'(strobeCnt[1] >= 1999 && strobeCnt[1] <= 2001), 64'd1);
      checkOutput("ch0Rate1of2", 64'(strobeCnt[0]), 64'd1499);

      // Reprogram ch0 while locked.
      applyStimulus(0, 1, 0, 32'h4000_0000, 3'b111);
      for (int k = 0; k < 40; k++) applyStimulus(0, 0, 0, 0, 3'b111);

      // Out-of-range select: handshake only.
      applyStimulus(0, 1, 3, 32'h1234_5678, 3'b111);
      for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 3'b111);

      // Zero increment silences a channel.
      applyStimulus(0, 1, 1, 32'h0, 3'b111);
      clearCounts();
      for (int k = 0; k < 1000; k++) applyStimulus(0, 0, 0, 0, 3'b111);
      checkOutput("ch1Silent", 64'(strobeCnt[1]), 64'd0);

      // Pause ch2 for 7 cycles mid-period.
      applyStimulus(0, 0, 0, 0, 3'b111);
      for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 3'b011);
      for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 3'b111);

      // Randomized traffic with occasional resets and enable changes.
      en = 3'b111;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 49) == 0) en = 3'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 599) == 0), ($urandom_range(0, 24) == 0),
                       2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom),
                       en);
      end

      // Reset coincident with a write: write ignored, defaults restored.
      applyStimulus(0, 1, 0, 32'h0000_0001, 3'b111);
      for (int k = 0; k < 30; k++) applyStimulus(0, 0, 0, 0, 3'b111);
      applyStimulus(1, 1, 0, 32'h0000_0001, 3'b111);
      applyStimulus(1, 0, 0, 0, 3'b111);
      clearCounts();
      for (int k = 0; k < 40; k++) applyStimulus(0, 0, 0, 0, 3'b111);
      checkOutput("ch0DefaultAfterRst", 64'(strobeCnt[0]), 64'd19);
      checkOutput("ch2DefaultAfterRst", 64'(strobeCnt[2]), 64'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
